// File: rtl/line_window_buffer.sv
// Raster-scan KSIZE x KSIZE sliding-window generator with circular line memories.
// Optional LWB_FRAME_CHECK_EN adds a sticky frame_err output for framing violations.
module line_window_buffer #(
   parameter int DATA_W       = 8,
   parameter int IMAGE_WIDTH  = 512,
   parameter int IMAGE_HEIGHT = 512,
   parameter int KSIZE        = 5
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   input  logic [DATA_W-1:0]                      in_data,
   input  logic                                   in_sof,
   output logic [KSIZE*KSIZE*DATA_W-1:0]          win_out,
   output logic                                   out_valid,
   output logic [$clog2(IMAGE_HEIGHT)-1:0]        out_row,
   output logic [$clog2(IMAGE_WIDTH)-1:0]         out_col,
   output logic                                   out_eof
`ifdef LWB_FRAME_CHECK_EN
   ,
   output logic                                   frame_err
`endif
);

   localparam int RW = $clog2(IMAGE_HEIGHT);
   localparam int CW = $clog2(IMAGE_WIDTH);
   localparam int R  = (KSIZE - 1) / 2;
   localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT - 1);
   localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);
   localparam logic [RW-1:0] R_ROW    = RW'(R);
   localparam logic [CW-1:0] R_COL    = CW'(R);
   localparam logic [RW-1:0] R2_ROW   = RW'(2 * R);
   localparam logic [CW-1:0] R2_COL   = CW'(2 * R);

   logic [RW-1:0] row, er, nr;
   logic [CW-1:0] col, ec, nc;
   logic          qualify, last_px;

   logic [DATA_W-1:0] line_mem [KSIZE-1][IMAGE_WIDTH];
   logic [DATA_W-1:0] col_vec  [KSIZE];
   logic [DATA_W-1:0] win      [KSIZE][KSIZE];

   // sof relocates the current pixel to (0,0); counters then continue from there
   always_comb begin
      er      = in_sof ? '0 : row;
      ec      = in_sof ? '0 : col;
      nr      = er;
      nc      = ec + 1'b1;
      if (ec == LAST_COL) begin
         nc = '0;
         nr = (er == LAST_ROW) ? '0 : er + 1'b1;
      end
      qualify = (er >= R2_ROW) && (ec >= R2_COL);
      last_px = (er == LAST_ROW) && (ec == LAST_COL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row <= '0;
         col <= '0;
      end else if (in_valid) begin
         row <= nr;
         col <= nc;
      end
   end

   // Read-before-write: each line returns what it held one full line ago
   always_comb begin
      for (int k = 0; k < KSIZE; k++) col_vec[k] = '0;
      col_vec[KSIZE-1] = in_data;
      for (int k = 0; k < KSIZE - 1; k++) col_vec[KSIZE-2-k] = line_mem[k][ec];
   end

   always_ff @(posedge clk) begin
      if (in_valid) begin
         line_mem[0][ec] <= in_data;
         for (int k = 1; k < KSIZE - 1; k++) line_mem[k][ec] <= line_mem[k-1][ec];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++) win[i][j] <= '0;
         out_valid <= 1'b0;
         out_eof   <= 1'b0;
         out_row   <= '0;
         out_col   <= '0;
      end else begin
         out_valid <= in_valid && qualify;
         out_eof   <= in_valid && qualify && last_px;
         if (in_valid) begin
            for (int i = 0; i < KSIZE; i++) begin
               for (int j = 0; j < KSIZE - 1; j++) win[i][j] <= win[i][j+1];
               win[i][KSIZE-1] <= col_vec[i];
            end
            if (qualify) begin
               out_row <= er - R_ROW;
               out_col <= ec - R_COL;
            end
         end
      end
   end

   always_comb begin
      win_out = '0;
      for (int i = 0; i < KSIZE; i++)
         for (int j = 0; j < KSIZE; j++)
            win_out[(i*KSIZE+j)*DATA_W +: DATA_W] = win[i][j];
   end

`ifdef LWB_FRAME_CHECK_EN
   logic frame_done;
   logic at_origin;

   assign at_origin = (row == '0) && (col == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else if (in_valid) begin
         if (last_px) frame_done <= 1'b1;
         if ((in_sof && !at_origin) || (!in_sof && at_origin && frame_done))
            frame_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer at W=8, H=6, K=3; pixel value = base + r*8 + c.
module tb_line_window_buffer;

   localparam int DW = 8;
   localparam int W  = 8;
   localparam int H  = 6;
   localparam int K  = 3;
   localparam int WB = K * K * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_sof;
   logic [WB-1:0] win_out;
   logic          out_valid;
   logic [2:0]    out_row;
   logic [2:0]    out_col;
   logic          out_eof;
`ifdef LWB_FRAME_CHECK_EN
   logic          frame_err;
`endif

   int checks = 0;
   int errors = 0;
   int vcount = 0;

   always #5 clk = ~clk;

   line_window_buffer #(.DATA_W(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .KSIZE(K)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
      .win_out(win_out), .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
      .out_eof(out_eof)
`ifdef LWB_FRAME_CHECK_EN
      , .frame_err(frame_err)
`endif
   );

   task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WB-1:0] exp_win(input int base, input int r, input int c);
      logic [WB-1:0] v;
      v = '0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            v[(i*K+j)*DW +: DW] = DW'(base + (r - 2 + i) * W + (c - 2 + j));
      return v;
   endfunction

   // Accept one pixel whose true position is (r,c) and check the resulting output
   task automatic send_px(input int base, input int r, input int c, input bit sof);
      bit ev;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DW'(base + r * W + c);
      in_sof   = sof;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      ev = (r >= 2) && (c >= 2);
      check($sformatf("valid(%0d,%0d)", r, c), WB'(out_valid), WB'(ev));
      check($sformatf("eof(%0d,%0d)", r, c), WB'(out_eof), WB'(ev && r == H-1 && c == W-1));
      if (out_valid) vcount++;
      if (ev) begin
         check($sformatf("row(%0d,%0d)", r, c), WB'(out_row), WB'(r - 1));
         check($sformatf("col(%0d,%0d)", r, c), WB'(out_col), WB'(c - 1));
         check($sformatf("win(%0d,%0d)", r, c), win_out, exp_win(base, r, c));
      end
   endtask

   task automatic stall_cycle();
      logic [WB-1:0] held;
      held = win_out;
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b1;
      in_data  = DW'($urandom);
      @(posedge clk);
      #1;
      in_sof = 1'b0;
      check("stall_valid", WB'(out_valid), '0);
      check("stall_hold", win_out, held);
   endtask

   task automatic send_frame(input int base, input bit sof, input bit stalls);
      vcount = 0;
      for (int idx = 0; idx < W * H; idx++) begin
         if (stalls) begin
            int n;
            n = $urandom_range(0, 2);
            for (int s = 0; s < n; s++) stall_cycle();
         end
         send_px(base, idx / W, idx % W, sof && idx == 0);
      end
      check("pulse_count", WB'(vcount), WB'((H - 2) * (W - 2)));
   endtask

   logic [WB-1:0] hand1, hand2, hand5;

   initial begin
      hand1 = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
      hand2 = {8'd118, 8'd117, 8'd116, 8'd110, 8'd109, 8'd108, 8'd102, 8'd101, 8'd100};
      hand5 = {8'd218, 8'd217, 8'd216, 8'd210, 8'd209, 8'd208, 8'd202, 8'd201, 8'd200};
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      in_sof = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", WB'(out_valid), '0);
      check("rst_win", win_out, '0);
      check("rst_rowcol", WB'({out_row, out_col, out_eof}), '0);
      rst = 1'b0;

      // Test 1/2: continuous frame, with hand-computed first and last windows
      vcount = 0;
      for (int idx = 0; idx < W * H; idx++) begin
         send_px(0, idx / W, idx % W, idx == 0);
         if (idx == 18) begin
            check("t1_first_win", win_out, hand1);
            check("t1_first_centre", WB'({out_row, out_col}), WB'({3'd1, 3'd1}));
         end
      end
      check("t2_pulse_count", WB'(vcount), WB'(24));
      check("t2_last_elem8", WB'(win_out[8*DW +: DW]), WB'(47));
      check("t2_last_centre", WB'({out_row, out_col, out_eof}), WB'({3'd4, 3'd6, 1'b1}));

      // Test 3: same frame with random stalls; sof at (0,0) is a no-op
      send_frame(0, 1'b1, 1'b1);

      // Test 4: back-to-back frames, second without sof
      send_frame(0, 1'b1, 1'b0);
      vcount = 0;
      for (int idx = 0; idx < W * H; idx++) begin
         send_px(100, idx / W, idx % W, 1'b0);
         if (idx == 18) check("t4_first_win", win_out, hand2);
      end
      check("t4_pulse_count", WB'(vcount), WB'(24));

      // Test 5: sof injected where the pixel would be (3,4)
      for (int idx = 0; idx < 3 * W + 4; idx++) send_px(0, idx / W, idx % W, idx == 0);
      vcount = 0;
      for (int idx = 0; idx <= 18; idx++) send_px(200, idx / W, idx % W, idx == 0);
      check("t5_single_window", WB'(vcount), WB'(1));
      check("t5_win", win_out, hand5);
      check("t5_centre", WB'({out_row, out_col}), WB'({3'd1, 3'd1}));
`ifdef LWB_FRAME_CHECK_EN
      check("t5_frame_err", WB'(frame_err), WB'(1));
`endif

      // Test 6: async reset mid-line while a window is being presented
      send_px(200, 2, 3, 1'b0);
      send_px(200, 2, 4, 1'b0);
      check("t6_pre_valid", WB'(out_valid), WB'(1));
      rst = 1'b1;
      #1;
      check("t6_async_valid", WB'({out_valid, out_eof}), '0);
      check("t6_async_rowcol", WB'({out_row, out_col}), '0);
      check("t6_async_win", win_out, '0);
      @(negedge clk);
      rst = 1'b0;
      vcount = 0;
      for (int idx = 0; idx < W * H; idx++) begin
         send_px(0, idx / W, idx % W, 1'b0);
         if (idx == 18) check("t6_first_win", win_out, hand1);
      end
      check("t6_pulse_count", WB'(vcount), WB'(24));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
